// File: rtl/pc_gen_pkg.sv
// Shared cpu package for the fetch PC generator.
// Holds the state encoding and the default reset/exception vectors.
package pc_gen_pkg;

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StPend = 1'b1
    } pc_state_e;

    localparam logic [31:0] DefResetVec = 32'h0000_3000;
    localparam logic [31:0] DefExcVec   = 32'h0000_4180;
    localparam int unsigned DefStep     = 4;

endpackage

// File: rtl/pc_gen.sv
// Fetch PC generator with exception/eret priority and stall-tolerant redirect holding.
// Define PC_ALIGN_CHECK_EN to add the registered misalign output and the auto-trap on misaligned PCs.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = DefResetVec,
    parameter logic [31:0] EXC_VEC   = DefExcVec,
    parameter int unsigned STEP      = DefStep
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
`ifdef PC_ALIGN_CHECK_EN
    output logic             misalign,
`endif
    output logic [WIDTH-1:0] pc,
    output logic             pend
);

    localparam logic [WIDTH-1:0] ResetVecW = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] ExcVecW   = WIDTH'(EXC_VEC);
    localparam logic [WIDTH-1:0] StepW     = WIDTH'(STEP);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             take_exc;

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    // A misaligned PC traps on the following edge exactly like exc_req.
    assign take_exc   = exc_req | misalign_q;
    assign misalign_d = ~take_exc & (|pc_d[1:0]);
    assign misalign   = misalign_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    assign take_exc = exc_req;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        if (take_exc) begin
            pc_d    = ExcVecW;
            state_d = StRun;
            tgt_d   = '0;
        end else if (eret_req) begin
            pc_d    = epc;
            state_d = StRun;
            tgt_d   = '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (br_valid) begin
                        if (en) begin
                            pc_d = br_target;
                        end else begin
                            tgt_d   = br_target;
                            state_d = StPend;
                        end
                    end else if (en) begin
                        pc_d = pc_q + StepW;
                    end
                end
                StPend: begin
                    if (en) begin
                        pc_d    = br_valid ? br_target : tgt_q;
                        state_d = StRun;
                    end else if (br_valid) begin
                        // Newest redirect wins while the stall lasts.
                        tgt_d = br_target;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            pc_q    <= ResetVecW;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    assign pc   = pc_q;
    assign pend = (state_q == StPend);

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: a 32-bit instance plus an 8-bit instance for wrap.
// Inputs change on the falling edge; outputs are checked on the falling edge after each rising edge.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc;
    logic        pend;
    logic [7:0]  pc8;
    logic        pend8;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign;
    logic        misalign8;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .WIDTH(32)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .br_valid (br_valid),
        .br_target(br_target),
        .exc_req  (exc_req),
        .eret_req (eret_req),
        .epc      (epc),
`ifdef PC_ALIGN_CHECK_EN
        .misalign (misalign),
`endif
        .pc       (pc),
        .pend     (pend)
    );

    pc_gen #(
        .WIDTH    (8),
        .RESET_VEC(32'h0000_00FC)
    ) u_dut8 (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .br_valid (br_valid),
        .br_target(br_target[7:0]),
        .exc_req  (exc_req),
        .eret_req (eret_req),
        .epc      (epc[7:0]),
`ifdef PC_ALIGN_CHECK_EN
        .misalign (misalign8),
`endif
        .pc       (pc8),
        .pend     (pend8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        en        = 1'b0;
        br_valid  = 1'b0;
        br_target = '0;
        exc_req   = 1'b0;
        eret_req  = 1'b0;
        epc       = '0;
    endtask

    initial begin
        reset = 1'b1;
        quiet();
        @(negedge clk);
        @(posedge clk);
        // Assert reset mid-cycle; outputs must follow without a clock edge.
        #3 reset = 1'b0;
        #1;
        check("reset_pc", pc, 32'h0000_3000);
        check("reset_pend", {31'd0, pend}, 32'd0);
        check("reset_pc8", {24'd0, pc8}, 32'h0000_00FC);
        @(negedge clk);
        en        = 1'b1;
        br_valid  = 1'b1;
        br_target = 32'h0000_3333;
        exc_req   = 1'b1;
        step();
        check("reset_ignores_req", pc, 32'h0000_3000);
        quiet();
        reset = 1'b1;

        // Sequential run from reset vector; the 8-bit copy wraps FC -> 00.
        en = 1'b1;
        step();
        check("seq_1", pc, 32'h0000_3004);
        check("wrap8", {24'd0, pc8}, 32'h0000_0000);
        step();
        check("seq_2", pc, 32'h0000_3008);
        step();
        check("seq_3", pc, 32'h0000_300C);

        // Stalled redirect held in PEND, then taken when en returns.
        en        = 1'b0;
        br_valid  = 1'b1;
        br_target = 32'h0000_3100;
        step();
        check("pend_enter_pc", pc, 32'h0000_300C);
        check("pend_enter_flag", {31'd0, pend}, 32'd1);
        br_valid = 1'b0;
        step();
        check("pend_hold1_pc", pc, 32'h0000_300C);
        check("pend_hold1_flag", {31'd0, pend}, 32'd1);
        step();
        check("pend_hold2_pc", pc, 32'h0000_300C);
        en = 1'b1;
        step();
        check("pend_release_pc", pc, 32'h0000_3100);
        check("pend_release_flag", {31'd0, pend}, 32'd0);

        // Newest redirect wins while stalled.
        en        = 1'b0;
        br_valid  = 1'b1;
        br_target = 32'h0000_3180;
        step();
        br_target = 32'h0000_3200;
        step();
        check("pend_overwrite_hold", pc, 32'h0000_3100);
        br_valid = 1'b0;
        en       = 1'b1;
        step();
        check("pend_newest_wins", pc, 32'h0000_3200);

        // Leaving PEND with a fresh branch the same cycle takes the fresh target.
        en        = 1'b0;
        br_valid  = 1'b1;
        br_target = 32'h0000_3300;
        step();
        en        = 1'b1;
        br_target = 32'h0000_3400;
        step();
        check("pend_fresh_br", pc, 32'h0000_3400);
        check("pend_fresh_flag", {31'd0, pend}, 32'd0);

        // Unstalled branch in RUN.
        br_target = 32'h0000_3500;
        step();
        check("run_branch", pc, 32'h0000_3500);
        br_valid = 1'b0;
        en       = 1'b0;
        step();
        check("run_stall_hold", pc, 32'h0000_3500);

        // exc beats eret and branch, even while stalled in PEND.
        br_valid  = 1'b1;
        br_target = 32'h0000_3600;
        step();
        exc_req  = 1'b1;
        eret_req = 1'b1;
        epc      = 32'h0000_3999;
        step();
        check("exc_priority_pc", pc, 32'h0000_4180);
        check("exc_priority_pend", {31'd0, pend}, 32'd0);
        quiet();
        eret_req = 1'b1;
        epc      = 32'h0000_3010;
        step();
        check("eret_pc", pc, 32'h0000_3010);
        quiet();
        en = 1'b1;
        step();
        check("after_eret_seq", pc, 32'h0000_3014);

        // eret out of PEND discards the held target.
        en        = 1'b0;
        br_valid  = 1'b1;
        br_target = 32'h0000_3700;
        step();
        br_valid = 1'b0;
        eret_req = 1'b1;
        epc      = 32'h0000_3020;
        step();
        check("eret_in_pend_pc", pc, 32'h0000_3020);
        check("eret_in_pend_flag", {31'd0, pend}, 32'd0);
        eret_req = 1'b0;
        en       = 1'b1;
        step();
        check("eret_discard", pc, 32'h0000_3024);

        // Reset during a stall drops the held redirect.
        en        = 1'b0;
        br_valid  = 1'b1;
        br_target = 32'h0000_3800;
        step();
        br_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("reset_stall_pc", pc, 32'h0000_3000);
        check("reset_stall_pend", {31'd0, pend}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b1;
        step();
        check("reset_discard", pc, 32'h0000_3004);

`ifdef PC_ALIGN_CHECK_EN
        br_valid  = 1'b1;
        br_target = 32'h0000_3002;
        step();
        check("misalign_set", {31'd0, misalign}, 32'd1);
        quiet();
        step();
        check("misalign_trap_pc", pc, 32'h0000_4180);
        check("misalign_clear", {31'd0, misalign}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
